// File: rtl/bus_map_pkg.sv
// Shared address map, STATUS layout and default sizes for the CPU data-bus responder.
package bus_map_pkg;

  localparam int unsigned RAM_DEPTH_DEF  = 240;
  localparam logic [7:0]  IO_BASE_DEF    = 8'hF0;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  // Register offsets inside the I/O page.
  localparam logic [7:0] OFS_OUT_DATA = 8'd0;
  localparam logic [7:0] OFS_STATUS   = 8'd1;
  localparam logic [7:0] OFS_TICK     = 8'd2;

  // STATUS bit positions.
  localparam int STAT_OVERFLOW = 7;
  localparam int STAT_COUNT_HI = 6;
  localparam int STAT_COUNT_LO = 4;
  localparam int STAT_FULL     = 1;
  localparam int STAT_EMPTY    = 0;

  // Target selected by the current bus address.
  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_OUT_DATA,
    SEL_STATUS,
    SEL_TICK,
    SEL_NONE
  } bus_sel_e;

  // Assemble the STATUS byte; unused bits read as zero.
  function automatic logic [7:0] pack_status(input logic       ovf,
                                             input logic [2:0] count,
                                             input logic       full,
                                             input logic       empty);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_OVERFLOW]               = ovf;
    s[STAT_COUNT_HI:STAT_COUNT_LO] = count;
    s[STAT_FULL]                   = full;
    s[STAT_EMPTY]                  = empty;
    return s;
  endfunction

endpackage

// File: rtl/out_fifo.sv
// Small output FIFO with explicit pointer wrap (depth need not be a power of two).
// A push into a full FIFO is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and flagged on 'drop'.
module out_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [2:0] count,
  output logic       full,
  output logic       empty,
  output logic       drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [2:0]    COUNT_MAX = 3'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == COUNT_MAX);
  assign empty   = (count == 3'd0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 3'd0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; when full with a concurrent pop, the slot being read is overwritten at the same edge.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; its contents are only visible through the valid count.
    if (!reset && push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_io_responder.sv
// CPU data-bus responder: byte RAM plus an I/O page holding an output FIFO,
// a STATUS register and a free-running TICK counter. Reads are combinational
// from AddressBus so the CPU sees data in the same cycle.
module mem_io_responder
  import bus_map_pkg::*;
#(
  parameter int unsigned RAM_DEPTH  = RAM_DEPTH_DEF,
  parameter logic [7:0]  IO_BASE    = IO_BASE_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] AddressBus,
  input  logic [7:0] WriteDataBus,
  input  logic       MemwriteEnable,
  output logic [7:0] ReadDataBus,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);

  localparam logic [8:0] RAM_TOP     = 9'(RAM_DEPTH);
  localparam logic [7:0] ADDR_OUT    = IO_BASE + OFS_OUT_DATA;
  localparam logic [7:0] ADDR_STATUS = IO_BASE + OFS_STATUS;
  localparam logic [7:0] ADDR_TICK   = IO_BASE + OFS_TICK;

  bus_sel_e   sel;
  logic [7:0] ram [RAM_DEPTH];
  logic [7:0] tick;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_drop;
  logic       push;
  logic       ovf_clear;

  // Address decode.
  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = SEL_NONE;
    if ({1'b0, AddressBus} < RAM_TOP)  sel = SEL_RAM;
    else if (AddressBus == ADDR_OUT)    sel = SEL_OUT_DATA;
    else if (AddressBus == ADDR_STATUS) sel = SEL_STATUS;
    else if (AddressBus == ADDR_TICK)   sel = SEL_TICK;
  end

  assign push      = MemwriteEnable && (sel == SEL_OUT_DATA);
  assign ovf_clear = MemwriteEnable && (sel == SEL_STATUS) && WriteDataBus[7];
  assign out_valid = !fifo_empty;

  out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (out_valid && out_ready),
    .din   (WriteDataBus),
    .dout  (out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // RAM store port; reset blocks a concurrent store but leaves contents untouched.
  always_ff @(posedge clk) begin
    if (!reset && MemwriteEnable && (sel == SEL_RAM)) ram[AddressBus] <= WriteDataBus;
  end

  // Free-running tick counter with bus load.
  always_ff @(posedge clk) begin
    if (reset)                                         tick <= 8'h00;
    else if (MemwriteEnable && (sel == SEL_TICK))      tick <= WriteDataBus;
    else                                               tick <= tick + 8'd1;
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset)          overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
    else if (ovf_clear) overflow <= 1'b0;
  end

  // Read data mux; write-only and unmapped locations return zero.
  always_comb begin
    ReadDataBus = 8'h00;
    case (sel)
      SEL_RAM:    ReadDataBus = ram[AddressBus];
      SEL_STATUS: ReadDataBus = pack_status(overflow, fifo_count, fifo_full, fifo_empty);
      SEL_TICK:   ReadDataBus = tick;
      default:    ReadDataBus = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, FIFO push/pop/drop, overflow clear, TICK wrap, reset.
`timescale 1ns/1ps
module tb_mem_io_responder;

  logic       clk;
  logic       reset;
  logic [7:0] AddressBus;
  logic [7:0] WriteDataBus;
  logic       MemwriteEnable;
  logic [7:0] ReadDataBus;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  mem_io_responder dut (
    .clk            (clk),
    .reset          (reset),
    .AddressBus     (AddressBus),
    .WriteDataBus   (WriteDataBus),
    .MemwriteEnable (MemwriteEnable),
    .ReadDataBus    (ReadDataBus),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    AddressBus     = a;
    WriteDataBus   = d;
    MemwriteEnable = 1'b1;
    cyc();
    MemwriteEnable = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    AddressBus = a;
    #1;
    check(tag, ReadDataBus, exp);
  endtask

  initial begin
    logic [7:0] drain_exp [4];
    drain_exp[0] = 8'h11; drain_exp[1] = 8'h22; drain_exp[2] = 8'h33; drain_exp[3] = 8'h44;

    reset = 1'b1; AddressBus = 8'h00; WriteDataBus = 8'h00;
    MemwriteEnable = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state
    check("rst_valid", {7'd0, out_valid}, 8'h00);
    check("rst_ovf",   {7'd0, overflow},  8'h00);
    read_chk("rst_status", 8'hF1, 8'h01);
    read_chk("rst_tick",   8'hF2, 8'h00);

    // 1. RAM write/read and unmapped read
    bus_write(8'h10, 8'h5A);
    read_chk("ram_10", 8'h10, 8'h5A);
    read_chk("unmap_f8", 8'hF8, 8'h00);
    read_chk("outdata_rd", 8'hF0, 8'h00);
    bus_write(8'hF8, 8'hAB);
    read_chk("unmap_f8_wr", 8'hF8, 8'h00);

    // 2. Fill FIFO with sink stalled, then overflow
    bus_write(8'hF0, 8'h11);
    check("push1_valid", {7'd0, out_valid}, 8'h01);
    check("push1_head",  out_data, 8'h11);
    bus_write(8'hF0, 8'h22);
    bus_write(8'hF0, 8'h33);
    bus_write(8'hF0, 8'h44);
    read_chk("full_status", 8'hF1, 8'h42);
    bus_write(8'hF0, 8'h55);
    check("drop_ovf", {7'd0, overflow}, 8'h01);
    read_chk("drop_status", 8'hF1, 8'hC2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_valid%0d", i), {7'd0, out_valid}, 8'h01);
      check($sformatf("drain_data%0d", i), out_data, drain_exp[i]);
      cyc();
    end
    out_ready = 1'b0;
    check("drained_valid", {7'd0, out_valid}, 8'h00);
    read_chk("drained_status", 8'hF1, 8'h81);

    // 3. Full FIFO: push with concurrent pop
    bus_write(8'hF0, 8'h11);
    bus_write(8'hF0, 8'h22);
    bus_write(8'hF0, 8'h33);
    bus_write(8'hF0, 8'h44);
    AddressBus = 8'hF0; WriteDataBus = 8'h66; MemwriteEnable = 1'b1; out_ready = 1'b1;
    cyc();
    MemwriteEnable = 1'b0; out_ready = 1'b0;
    read_chk("swap_status", 8'hF1, 8'hC2);
    check("swap_head", out_data, 8'h22);

    // 4. Overflow clear: bit7=0 ignored, bit7=1 clears, new drop sets again
    bus_write(8'hF1, 8'h7F);
    check("noclr_ovf", {7'd0, overflow}, 8'h01);
    bus_write(8'hF1, 8'h80);
    check("clr_ovf", {7'd0, overflow}, 8'h00);
    read_chk("clr_status", 8'hF1, 8'h42);
    bus_write(8'hF0, 8'h77);
    check("redrop_ovf", {7'd0, overflow}, 8'h01);
    bus_write(8'hF1, 8'h80);
    check("reclr_ovf", {7'd0, overflow}, 8'h00);

    // 5. TICK load and wrap
    bus_write(8'hF2, 8'hFE);
    read_chk("tick_fe", 8'hF2, 8'hFE);
    cyc();
    read_chk("tick_ff", 8'hF2, 8'hFF);
    cyc();
    read_chk("tick_00", 8'hF2, 8'h00);
    cyc();
    read_chk("tick_01", 8'hF2, 8'h01);

    // 6. Reset mid-drain with count=3, racing a push and a pop
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    read_chk("cnt3_status", 8'hF1, 8'h30);
    check("cnt3_head", out_data, 8'h33);
    reset = 1'b1; out_ready = 1'b1;
    AddressBus = 8'hF0; WriteDataBus = 8'h99; MemwriteEnable = 1'b1;
    cyc();
    reset = 1'b0; out_ready = 1'b0; MemwriteEnable = 1'b0;
    check("post_rst_valid", {7'd0, out_valid}, 8'h00);
    check("post_rst_ovf",   {7'd0, overflow},  8'h00);
    read_chk("post_rst_status", 8'hF1, 8'h01);
    read_chk("post_rst_tick",   8'hF2, 8'h00);
    read_chk("post_rst_ram",    8'h10, 8'h5A);
    cyc();
    read_chk("post_rst_tick1",  8'hF2, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
